// File: rtl/sm_restore_serial.sv
// sm_restore_serial: bit-serial reconstruction of a subtractor's minuend.
// Given the magnitude/sign from an N-bit magnitude subtractor and the original
// subtrahend B, rebuilds A = B + mag (pos=1) or A = B - mag (pos=0) one bit per
// clock, LSB first, behind a start/busy/done handshake. Subtraction is done as
// B + ~mag + 1, so a single ripple-carry bit cell serves both directions.
module sm_restore_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] mag,
    input  logic         pos,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] A_out,
    output logic         ovf
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;     // index of the bit processed on the next RUN edge
    logic [N-1:0]  b_q,     b_d;       // subtrahend, shifted right so bit i sits at [0]
    logic [N-1:0]  op_q,    op_d;      // mag or ~mag, shifted the same way
    logic          c_q,     c_d;       // running carry between bit positions
    logic          pos_q,   pos_d;     // latched direction, decides how the carry maps to ovf
    logic [N-1:0]  res_q,   res_d;     // partial result, filled from the MSB side
    logic [N-1:0]  a_out_q, a_out_d;
    logic          ovf_q,   ovf_d;

    logic          sum_bit;
    logic          carry_bit;
    logic [N-1:0]  res_shifted;

    // One full-adder cell working on the current LSBs of the operand shifters.
    always_comb begin
        sum_bit     = b_q[0] ^ op_q[0] ^ c_q;
        carry_bit   = (b_q[0] & op_q[0]) | (b_q[0] & c_q) | (op_q[0] & c_q);
        res_shifted = {sum_bit, res_q[N-1:1]};
    end

    // Next-state and datapath control for the IDLE/RUN/DONE handshake.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        op_d    = op_q;
        c_d     = c_q;
        pos_d   = pos_q;
        res_d   = res_q;
        a_out_d = a_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Accept: capture operands; pos=0 turns the add into B + ~mag + 1.
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    b_d     = B;
                    op_d    = pos ? mag : ~mag;
                    c_d     = ~pos;
                    pos_d   = pos;
                    res_d   = '0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // start and the input ports are deliberately ignored here.
                b_d   = b_q >> 1;
                op_d  = op_q >> 1;
                c_d   = carry_bit;
                res_d = res_shifted;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Final bit: publish the result. A carry out means overflow
                    // for an add, while its absence means a borrow for a subtract.
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    a_out_d = res_shifted;
                    ovf_d   = pos_q ? carry_bit : ~carry_bit;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any computation in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            b_q     <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
            pos_q   <= 1'b0;
            res_q   <= '0;
            a_out_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            op_q    <= op_d;
            c_q     <= c_d;
            pos_q   <= pos_d;
            res_q   <= res_d;
            a_out_q <= a_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign A_out = a_out_q;
    assign ovf   = ovf_q;

endmodule
